// File: rtl/sim_run_ctl.sv
// sim_run_ctl -- simulation run controller.
//
// Sequences a set of channels through a common run:
//   HOLD    : every channel reset asserted for RST_CYCLES cycles.
//   RELEASE : channel resets drop one by one, STAGGER cycles apart
//             (channel 0 first, all together when STAGGER is 0).
//   RUN     : counts cycles and collects sticky per-channel done flags
//             until every channel has reported done or the watchdog fires.
//   FINISH  : results frozen until restart or reset.
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   synchronous active-high reset (wins over restart)
//   restart      in   single-cycle request to replay the sequence from HOLD
//   done         in   [NUM_CH]  per-channel completion (pulse or level)
//   ch_reset     out  [NUM_CH]  per-channel synchronous active-high reset
//   running      out  high while in RUN
//   cycle_count  out  [CYCLE_W] cycles spent in RUN, saturating
//   done_seen    out  [NUM_CH]  sticky per-channel done flags
//   finish       out  high while in FINISH
//   timeout      out  high when FINISH was forced by the watchdog
//
// Every output is a register loaded from the next-state logic, so outputs
// change together with the state they describe.
module sim_run_ctl #(
    parameter int NUM_CH     = 2,
    parameter int RST_CYCLES = 10,
    parameter int STAGGER    = 4,
    parameter int CYCLE_W    = 32,
    parameter int TIMEOUT    = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               restart,
    input  logic [NUM_CH-1:0]  done,
    output logic [NUM_CH-1:0]  ch_reset,
    output logic               running,
    output logic [CYCLE_W-1:0] cycle_count,
    output logic [NUM_CH-1:0]  done_seen,
    output logic               finish,
    output logic               timeout
);

    localparam int HOLD_W   = $clog2(RST_CYCLES + 1);
    // RELEASE cycle index at which the last channel is already released
    localparam int REL_LAST = (NUM_CH - 1) * STAGGER;
    localparam int REL_W    = (REL_LAST > 0) ? $clog2(REL_LAST + 1) : 1;
    localparam bit WD_EN    = (TIMEOUT != 0);
    localparam logic [63:0] TO_LAST = (TIMEOUT > 0) ? 64'(TIMEOUT - 1) : 64'd0;

    typedef enum logic [1:0] {
        S_HOLD,
        S_RELEASE,
        S_RUN,
        S_FINISH
    } state_e;

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [REL_W-1:0]   rel_cnt_q, rel_cnt_d;
    logic [NUM_CH-1:0]  ch_reset_q, ch_reset_d;
    logic               running_q, running_d;
    logic [CYCLE_W-1:0] cycle_count_q, cycle_count_d;
    logic [NUM_CH-1:0]  done_seen_q, done_seen_d;
    logic               finish_q, finish_d;
    logic               timeout_q, timeout_d;

    // due_entry: channel released on the RELEASE entry edge (offset 0).
    // due_step : channel due at the next RELEASE cycle index.
    logic [NUM_CH-1:0]  due_entry;
    logic [NUM_CH-1:0]  due_step;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_due
            assign due_entry[gi] = ((gi * STAGGER) == 0);
            assign due_step[gi]  = ((32'(rel_cnt_q) + 32'd1) >= 32'(gi * STAGGER));
        end
    endgenerate

    logic all_done;
    logic wd_expired;
    assign all_done   = &(done_seen_q | done);
    assign wd_expired = WD_EN && (64'(cycle_count_q) == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_HOLD;
            hold_cnt_q    <= '0;
            rel_cnt_q     <= '0;
            ch_reset_q    <= '1;
            running_q     <= 1'b0;
            cycle_count_q <= '0;
            done_seen_q   <= '0;
            finish_q      <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            rel_cnt_q     <= rel_cnt_d;
            ch_reset_q    <= ch_reset_d;
            running_q     <= running_d;
            cycle_count_q <= cycle_count_d;
            done_seen_q   <= done_seen_d;
            finish_q      <= finish_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        rel_cnt_d     = rel_cnt_q;
        ch_reset_d    = ch_reset_q;
        cycle_count_d = cycle_count_q;
        done_seen_d   = done_seen_q;
        timeout_d     = timeout_q;

        if (restart) begin
            // Restart behaves like a fresh reset release: the next cycle is
            // HOLD with a cleared hold counter, so the replay timing matches.
            state_d       = S_HOLD;
            hold_cnt_d    = '0;
            rel_cnt_d     = '0;
            ch_reset_d    = '1;
            cycle_count_d = '0;
            done_seen_d   = '0;
            timeout_d     = 1'b0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    ch_reset_d = '1;
                    if (hold_cnt_q == HOLD_W'(RST_CYCLES)) begin
                        state_d    = S_RELEASE;
                        rel_cnt_d  = '0;
                        ch_reset_d = ~due_entry;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (rel_cnt_q == REL_W'(REL_LAST)) begin
                        state_d       = S_RUN;
                        cycle_count_d = '0;
                    end else begin
                        rel_cnt_d  = rel_cnt_q + REL_W'(1);
                        ch_reset_d = ch_reset_q & ~due_step;
                    end
                end
                S_RUN: begin
                    done_seen_d = done_seen_q | done;
                    // Completion is tested first so it wins over a
                    // watchdog expiry in the same cycle.
                    if (all_done) begin
                        state_d = S_FINISH;
                    end else if (wd_expired) begin
                        state_d   = S_FINISH;
                        timeout_d = 1'b1;
                    end else if (cycle_count_q != '1) begin
                        cycle_count_d = cycle_count_q + CYCLE_W'(1);
                    end
                end
                default: begin
                    // S_FINISH: everything holds until restart or reset
                end
            endcase
        end

        running_d = (state_d == S_RUN);
        finish_d  = (state_d == S_FINISH);
    end

    assign ch_reset    = ch_reset_q;
    assign running     = running_q;
    assign cycle_count = cycle_count_q;
    assign done_seen   = done_seen_q;
    assign finish      = finish_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_sim_run_ctl.sv
// Testbench for sim_run_ctl. Five instances with different parameter sets
// are exercised one after another on a shared clock. The stimulus process
// pushes expected output snapshots (tagged with instance and cycle) into a
// queue; a monitor on the falling edge pops each entry when its cycle
// arrives and compares it with the observed outputs.
`timescale 1ns/1ps
module tb_sim_run_ctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst [5];
    logic        rsr [5];
    logic [15:0] dn  [5];

    logic [15:0] o_chr [5];
    logic        o_run [5];
    logic [31:0] o_cc  [5];
    logic [15:0] o_ds  [5];
    logic        o_fin [5];
    logic        o_to  [5];

    logic [1:0]  chr0, ds0, chr1, ds1, chr3, ds3;
    logic [3:0]  chr2, ds2;
    logic [2:0]  chr4, ds4;
    logic [31:0] cc0, cc1, cc2, cc4;
    logic [3:0]  cc3;

    // 0: defaults
    sim_run_ctl u0 (
        .clk(clk), .reset(rst[0]), .restart(rsr[0]), .done(dn[0][1:0]),
        .ch_reset(chr0), .running(o_run[0]), .cycle_count(cc0),
        .done_seen(ds0), .finish(o_fin[0]), .timeout(o_to[0]));
    // 1: short watchdog
    sim_run_ctl #(.TIMEOUT(50)) u1 (
        .clk(clk), .reset(rst[1]), .restart(rsr[1]), .done(dn[1][1:0]),
        .ch_reset(chr1), .running(o_run[1]), .cycle_count(cc1),
        .done_seen(ds1), .finish(o_fin[1]), .timeout(o_to[1]));
    // 2: four channels, stagger 3
    sim_run_ctl #(.NUM_CH(4), .STAGGER(3)) u2 (
        .clk(clk), .reset(rst[2]), .restart(rsr[2]), .done(dn[2][3:0]),
        .ch_reset(chr2), .running(o_run[2]), .cycle_count(cc2),
        .done_seen(ds2), .finish(o_fin[2]), .timeout(o_to[2]));
    // 3: narrow counter, watchdog off
    sim_run_ctl #(.CYCLE_W(4), .TIMEOUT(0)) u3 (
        .clk(clk), .reset(rst[3]), .restart(rsr[3]), .done(dn[3][1:0]),
        .ch_reset(chr3), .running(o_run[3]), .cycle_count(cc3),
        .done_seen(ds3), .finish(o_fin[3]), .timeout(o_to[3]));
    // 4: three channels, no stagger, one hold cycle
    sim_run_ctl #(.NUM_CH(3), .STAGGER(0), .RST_CYCLES(1), .TIMEOUT(0)) u4 (
        .clk(clk), .reset(rst[4]), .restart(rsr[4]), .done(dn[4][2:0]),
        .ch_reset(chr4), .running(o_run[4]), .cycle_count(cc4),
        .done_seen(ds4), .finish(o_fin[4]), .timeout(o_to[4]));

    assign o_chr[0] = 16'(chr0);  assign o_ds[0] = 16'(ds0);  assign o_cc[0] = cc0;
    assign o_chr[1] = 16'(chr1);  assign o_ds[1] = 16'(ds1);  assign o_cc[1] = cc1;
    assign o_chr[2] = 16'(chr2);  assign o_ds[2] = 16'(ds2);  assign o_cc[2] = cc2;
    assign o_chr[3] = 16'(chr3);  assign o_ds[3] = 16'(ds3);  assign o_cc[3] = 32'(cc3);
    assign o_chr[4] = 16'(chr4);  assign o_ds[4] = 16'(ds4);  assign o_cc[4] = cc4;

    typedef struct {
        int          dut;
        int          at;
        logic [15:0] chr;
        logic        run;
        logic [31:0] cc;
        logic [15:0] ds;
        logic        fin;
        logic        to;
        string       nm;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   base;

    task automatic exp_push(input int d, input int off, input logic [15:0] chr,
                            input logic run, input logic [31:0] cc,
                            input logic [15:0] ds, input logic fin,
                            input logic to, input string nm);
        exp_t e;
        e.dut = d; e.at = base + off; e.chr = chr; e.run = run; e.cc = cc;
        e.ds = ds; e.fin = fin; e.to = to; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare every entry whose cycle has arrived.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            mon_e = sb.pop_front();
            total++;
            if (mon_e.at < cyc) begin
                bad++;
                $display("FAIL %s dut%0d: check for cycle %0d missed at cycle %0d",
                         mon_e.nm, mon_e.dut, mon_e.at, cyc);
            end else if (o_chr[mon_e.dut] !== mon_e.chr || o_run[mon_e.dut] !== mon_e.run ||
                         o_cc[mon_e.dut] !== mon_e.cc || o_ds[mon_e.dut] !== mon_e.ds ||
                         o_fin[mon_e.dut] !== mon_e.fin || o_to[mon_e.dut] !== mon_e.to) begin
                bad++;
                $display("FAIL %s dut%0d cyc %0d: got chr=%h run=%b cc=%0d ds=%h fin=%b to=%b, want chr=%h run=%b cc=%0d ds=%h fin=%b to=%b",
                         mon_e.nm, mon_e.dut, cyc,
                         o_chr[mon_e.dut], o_run[mon_e.dut], o_cc[mon_e.dut],
                         o_ds[mon_e.dut], o_fin[mon_e.dut], o_to[mon_e.dut],
                         mon_e.chr, mon_e.run, mon_e.cc, mon_e.ds, mon_e.fin, mon_e.to);
            end else begin
                $display("ok   %s dut%0d cyc %0d", mon_e.nm, mon_e.dut, cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

    initial begin
        for (int d = 0; d < 5; d++) begin
            rst[d] = 1'b1; rsr[d] = 1'b0; dn[d] = '0;
        end
        tick(3);

        // ---- dut0: default timing, done handling, restart replay ----
        base = cyc;
        exp_push(0,  0, 16'h3, 0,  0, 16'h0, 0, 0, "t1_reset_state");
        exp_push(0, 10, 16'h3, 0,  0, 16'h0, 0, 0, "t1_hold_last");
        exp_push(0, 11, 16'h2, 0,  0, 16'h0, 0, 0, "t1_ch0_drop");
        exp_push(0, 14, 16'h2, 0,  0, 16'h0, 0, 0, "t1_ch1_still_held");
        exp_push(0, 15, 16'h0, 0,  0, 16'h0, 0, 0, "t1_ch1_drop");
        exp_push(0, 16, 16'h0, 1,  0, 16'h0, 0, 0, "t1_run_start");
        exp_push(0, 21, 16'h0, 1,  5, 16'h0, 0, 0, "t1_cc5");
        exp_push(0, 22, 16'h0, 1,  6, 16'h1, 0, 0, "t1_done0_seen");
        exp_push(0, 36, 16'h0, 1, 20, 16'h1, 0, 0, "t1_cc20");
        exp_push(0, 37, 16'h0, 0, 20, 16'h3, 1, 0, "t1_finish");
        exp_push(0, 40, 16'h0, 0, 20, 16'h3, 1, 0, "t1_finish_hold");
        exp_push(0, 41, 16'h3, 0,  0, 16'h0, 0, 0, "t1_restart_clear");
        exp_push(0, 52, 16'h2, 0,  0, 16'h0, 0, 0, "t1_replay_ch0");
        exp_push(0, 56, 16'h0, 0,  0, 16'h0, 0, 0, "t1_replay_ch1");
        exp_push(0, 57, 16'h0, 1,  0, 16'h0, 0, 0, "t1_replay_run");
        rst[0] = 1'b0;
        tick(2);  dn[0] = 16'h2;      // done during HOLD must be ignored
        tick(1);  dn[0] = 16'h0;
        tick(18); dn[0] = 16'h1;      // seen while cycle_count = 5
        tick(1);  dn[0] = 16'h0;
        tick(14); dn[0] = 16'h2;      // held from cycle_count = 20
        tick(4);  dn[0] = 16'h0; rsr[0] = 1'b1;
        tick(1);  rsr[0] = 1'b0;
        tick(16);
        rst[0] = 1'b1;

        // ---- dut1: watchdog expiry, then completion at the expiry cycle ----
        base = cyc;
        exp_push(1,   0, 16'h3, 0,  0, 16'h0, 0, 0, "t2_reset_state");
        exp_push(1,  16, 16'h0, 1,  0, 16'h0, 0, 0, "t2_run_start");
        exp_push(1,  65, 16'h0, 1, 49, 16'h0, 0, 0, "t2_cc49");
        exp_push(1,  66, 16'h0, 0, 49, 16'h0, 1, 1, "t2_timeout_finish");
        exp_push(1,  70, 16'h0, 0, 49, 16'h0, 1, 1, "t2_timeout_hold");
        exp_push(1,  71, 16'h3, 0,  0, 16'h0, 0, 0, "t2_restart_clear");
        exp_push(1,  87, 16'h0, 1,  0, 16'h0, 0, 0, "t2_rerun_start");
        exp_push(1, 136, 16'h0, 1, 49, 16'h0, 0, 0, "t2_rerun_cc49");
        exp_push(1, 137, 16'h0, 0, 49, 16'h3, 1, 0, "t2_done_beats_wd");
        exp_push(1, 139, 16'h0, 0, 49, 16'h3, 1, 0, "t2_done_hold");
        exp_push(1, 140, 16'h3, 0,  0, 16'h0, 0, 0, "t2_reset_and_restart");
        rst[1] = 1'b0;
        tick(70); rsr[1] = 1'b1;
        tick(1);  rsr[1] = 1'b0;
        tick(65); dn[1] = 16'h3;      // all done while cycle_count = 49
        tick(1);  dn[1] = 16'h0;
        tick(2);  rst[1] = 1'b1; rsr[1] = 1'b1;
        tick(1);  rsr[1] = 1'b0;

        // ---- dut2: restart in the middle of RELEASE ----
        base = cyc;
        exp_push(2,  0, 16'hF, 0, 0, 16'h0, 0, 0, "t3_reset_state");
        exp_push(2, 10, 16'hF, 0, 0, 16'h0, 0, 0, "t3_hold_last");
        exp_push(2, 11, 16'hE, 0, 0, 16'h0, 0, 0, "t3_ch0_drop");
        exp_push(2, 14, 16'hC, 0, 0, 16'h0, 0, 0, "t3_ch1_drop");
        exp_push(2, 15, 16'hC, 0, 0, 16'h0, 0, 0, "t3_before_restart");
        exp_push(2, 16, 16'hF, 0, 0, 16'h0, 0, 0, "t3_restart_reassert");
        exp_push(2, 26, 16'hF, 0, 0, 16'h0, 0, 0, "t3_replay_hold_last");
        exp_push(2, 27, 16'hE, 0, 0, 16'h0, 0, 0, "t3_replay_ch0");
        exp_push(2, 30, 16'hC, 0, 0, 16'h0, 0, 0, "t3_replay_ch1");
        exp_push(2, 33, 16'h8, 0, 0, 16'h0, 0, 0, "t3_replay_ch2");
        exp_push(2, 36, 16'h0, 0, 0, 16'h0, 0, 0, "t3_replay_ch3");
        exp_push(2, 37, 16'h0, 1, 0, 16'h0, 0, 0, "t3_replay_run");
        rst[2] = 1'b0;
        tick(15); rsr[2] = 1'b1;
        tick(1);  rsr[2] = 1'b0;
        tick(21);
        rst[2] = 1'b1;

        // ---- dut3: 4-bit counter saturation, no watchdog ----
        base = cyc;
        exp_push(3,  0, 16'h3, 0,  0, 16'h0, 0, 0, "t4_reset_state");
        exp_push(3, 16, 16'h0, 1,  0, 16'h0, 0, 0, "t4_run_start");
        exp_push(3, 30, 16'h0, 1, 14, 16'h0, 0, 0, "t4_cc14");
        exp_push(3, 31, 16'h0, 1, 15, 16'h0, 0, 0, "t4_cc15");
        exp_push(3, 45, 16'h0, 1, 15, 16'h0, 0, 0, "t4_cc_saturated");
        rst[3] = 1'b0;
        tick(45);
        rst[3] = 1'b1;

        // ---- dut4: simultaneous release, reset over restart mid-RUN ----
        base = cyc;
        exp_push(4, 0, 16'h7, 0, 0, 16'h0, 0, 0, "t5_reset_state");
        exp_push(4, 1, 16'h7, 0, 0, 16'h0, 0, 0, "t5_hold");
        exp_push(4, 2, 16'h0, 0, 0, 16'h0, 0, 0, "t5_all_drop");
        exp_push(4, 3, 16'h0, 1, 0, 16'h0, 0, 0, "t5_run_start");
        exp_push(4, 4, 16'h0, 1, 1, 16'h0, 0, 0, "t5_cc1");
        exp_push(4, 5, 16'h7, 0, 0, 16'h0, 0, 0, "t5_reset_mid_run");
        exp_push(4, 7, 16'h0, 0, 0, 16'h0, 0, 0, "t5_rerelease");
        exp_push(4, 8, 16'h0, 1, 0, 16'h0, 0, 0, "t5_rerun");
        rst[4] = 1'b0;
        tick(4);  rst[4] = 1'b1; rsr[4] = 1'b1;
        tick(1);  rst[4] = 1'b0; rsr[4] = 1'b0;
        tick(3);

        tick(3);
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending checks, want 0", sb.size());
            bad   += sb.size();
            total += sb.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
